pipe_share_ctrl: RTL and testbench

- Controller that shares one instance of the 3-stage arithmetic pipeline (F = (A+B+C-D)*D, N-bit, no stall) among NREQ requesters.
- Arbitrates round-robin, issues at most one operand set per cycle, and tracks a valid/ID tag through a shift register matched to the pipeline latency.
- Returns each result to the requester that issued it.
- Sits between client blocks and the pipeline instance; the pipeline is instantiated outside and wired to pipe_* ports.

---
 rtl/pipe_share_ctrl_pkg.sv | 27 ++
 rtl/pipe_share_ctrl_rr_arbiter.sv | 40 ++++
 rtl/pipe_share_ctrl.sv | 142 ++++++++++++++
 tb/tb_pipe_share_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_share_ctrl_pkg.sv
// Shared constants and helpers for the pipeline-sharing controller.
// A tag is packed as {v, id}, so v sits at bit IDW and id occupies [IDW-1:0].
package pipe_share_ctrl_pkg;

    localparam int LAT_DEFAULT = 3;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // A single requester still needs a one-bit ID field.
    function automatic int id_width(input int nreq);
        return (clog2(nreq) < 1) ? 1 : clog2(nreq);
    endfunction

    function automatic int tag_width(input int idw);
        return idw + 1;
    endfunction

endpackage

// File: rtl/pipe_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr, wrapping modulo NREQ.
// At most one grant bit is high, and none while en is low.
module pipe_share_ctrl_rr_arbiter
    import pipe_share_ctrl_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            grant_any
);

    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            idx = sum[IDW-1:0];
            if (en && !grant_any && req[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = idx;
                grant_any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_share_ctrl.sv
// Shares one fixed-latency F = (A+B+C-D)*D pipeline among NREQ requesters and
// routes each result back to its issuer using a {v, id} tag shift register.
module pipe_share_ctrl
    import pipe_share_ctrl_pkg::*;
#(
    parameter int N    = 10,
    parameter int NREQ = 2,
    parameter int LAT  = LAT_DEFAULT,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*N-1:0]          req_a,
    input  logic [NREQ*N-1:0]          req_b,
    input  logic [NREQ*N-1:0]          req_c,
    input  logic [NREQ*N-1:0]          req_d,
    output logic [N-1:0]               pipe_a,
    output logic [N-1:0]               pipe_b,
    output logic [N-1:0]               pipe_c,
    output logic [N-1:0]               pipe_d,
    input  logic [N-1:0]               pipe_f,
    output logic [NREQ-1:0]            resp_valid,
    output logic [IDW-1:0]             resp_id,
    output logic [N-1:0]               resp_f,
    output logic [clog2(LAT+1):0]      inflight,
    output logic                       idle
);

    localparam int TW = tag_width(IDW);
    localparam int CW = clog2(LAT+1) + 1;

    logic [N-1:0]    op_a [NREQ];
    logic [N-1:0]    op_b [NREQ];
    logic [N-1:0]    op_c [NREQ];
    logic [N-1:0]    op_d [NREQ];

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic            grant_any;
    logic            arb_en;

    logic [IDW-1:0]  ptr_reg, ptr_next;
    logic [TW-1:0]   tag_reg  [LAT];
    logic [TW-1:0]   tag_next [LAT];
    logic [CW-1:0]   inflight_reg, inflight_next;
    logic [NREQ-1:0] resp_valid_reg;
    logic [IDW-1:0]  resp_id_reg;
    logic [N-1:0]    resp_f_reg;
    logic [TW-1:0]   tag_out;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ops
            assign op_a[gi] = req_a[gi*N +: N];
            assign op_b[gi] = req_b[gi*N +: N];
            assign op_c[gi] = req_c[gi*N +: N];
            assign op_d[gi] = req_d[gi*N +: N];
        end
    endgenerate

    // Gating by rst_n keeps grants and pipeline inputs at zero while reset is held.
    assign arb_en = rst_n & ~flush;

    pipe_share_ctrl_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr_reg),
        .en        (arb_en),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_any (grant_any)
    );

    assign req_ready = grant;
    assign pipe_a    = grant_any ? op_a[grant_id] : '0;
    assign pipe_b    = grant_any ? op_b[grant_id] : '0;
    assign pipe_c    = grant_any ? op_c[grant_id] : '0;
    assign pipe_d    = grant_any ? op_d[grant_id] : '0;

    always_comb begin
        ptr_next = ptr_reg;
        if (grant_any) begin
            ptr_next = (grant_id == IDW'(NREQ-1)) ? '0 : grant_id + IDW'(1);
        end
    end

    // Flush clears every v bit; inflight is derived from the next tags so it tracks them exactly.
    always_comb begin
        tag_next[0] = {grant_any, grant_id};
        for (int s = 1; s < LAT; s++) begin
            tag_next[s] = tag_reg[s-1];
        end
        if (flush) begin
            for (int s = 0; s < LAT; s++) begin
                tag_next[s][IDW] = 1'b0;
            end
        end
        inflight_next = '0;
        for (int s = 0; s < LAT; s++) begin
            inflight_next = inflight_next + CW'(tag_next[s][IDW]);
        end
    end

    assign tag_out = tag_reg[LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg        <= '0;
            inflight_reg   <= '0;
            resp_valid_reg <= '0;
            resp_id_reg    <= '0;
            resp_f_reg     <= '0;
            for (int s = 0; s < LAT; s++) begin
                tag_reg[s] <= '0;
            end
        end else begin
            ptr_reg      <= ptr_next;
            inflight_reg <= inflight_next;
            for (int s = 0; s < LAT; s++) begin
                tag_reg[s] <= tag_next[s];
            end
            if (tag_out[IDW] && !flush) begin
                resp_valid_reg <= NREQ'(1) << tag_out[IDW-1:0];
                resp_id_reg    <= tag_out[IDW-1:0];
                resp_f_reg     <= pipe_f;
            end else begin
                resp_valid_reg <= '0;
            end
        end
    end

    assign resp_valid = resp_valid_reg;
    assign resp_id    = resp_id_reg;
    assign resp_f     = resp_f_reg;
    assign inflight   = inflight_reg;
    assign idle       = (inflight_reg == '0) && (resp_valid_reg == '0);

endmodule

// File: tb/tb_pipe_share_ctrl.sv
// Directed bench for pipe_share_ctrl: a 2-requester instance driving a model of the
// 3-stage F = (A+B+C-D)*D pipeline, plus a 3-requester instance for arbitration order.
module tb_pipe_share_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;

    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [19:0] req_a = '0, req_b = '0, req_c = '0, req_d = '0;
    logic [9:0]  pipe_a, pipe_b, pipe_c, pipe_d, pipe_f;
    logic [1:0]  resp_valid;
    logic [0:0]  resp_id;
    logic [9:0]  resp_f;
    logic [2:0]  inflight;
    logic        idle;

    logic [2:0]  req_valid3 = '0;
    logic [2:0]  req_ready3;
    logic [29:0] req_ops3 = '0;
    logic [9:0]  pipe_a3, pipe_b3, pipe_c3, pipe_d3;
    logic [9:0]  pipe_f3 = '0;
    logic [2:0]  resp_valid3;
    logic [1:0]  resp_id3;
    logic [9:0]  resp_f3;
    logic [2:0]  inflight3;
    logic        idle3;

    logic [9:0]  p1 = '0, p2 = '0, p3 = '0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_share_ctrl #(.N(10), .NREQ(2), .LAT(3), .IDW(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_c      (req_c),
        .req_d      (req_d),
        .pipe_a     (pipe_a),
        .pipe_b     (pipe_b),
        .pipe_c     (pipe_c),
        .pipe_d     (pipe_d),
        .pipe_f     (pipe_f),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_f     (resp_f),
        .inflight   (inflight),
        .idle       (idle)
    );

    pipe_share_ctrl #(.N(10), .NREQ(3), .LAT(3), .IDW(2)) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req_valid  (req_valid3),
        .req_ready  (req_ready3),
        .req_a      (req_ops3),
        .req_b      (req_ops3),
        .req_c      (req_ops3),
        .req_d      (req_ops3),
        .pipe_a     (pipe_a3),
        .pipe_b     (pipe_b3),
        .pipe_c     (pipe_c3),
        .pipe_d     (pipe_d3),
        .pipe_f     (pipe_f3),
        .resp_valid (resp_valid3),
        .resp_id    (resp_id3),
        .resp_f     (resp_f3),
        .inflight   (inflight3),
        .idle       (idle3)
    );

    // Independent pipeline model: result valid three edges after operand capture.
    always @(posedge clk) begin
        p1 <= (pipe_a + pipe_b + pipe_c - pipe_d) * pipe_d;
        p2 <= p1;
        p3 <= p2;
    end
    assign pipe_f = p3;

    always @(negedge clk) begin
        if (rst_n && resp_valid != 2'b00) begin
            $display("resp: valid=%b id=%0d f=%0d inflight=%0d", resp_valid, resp_id, resp_f, inflight);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input int a, input int b, input int c, input int d);
        req_a[i*10 +: 10] = 10'(a);
        req_b[i*10 +: 10] = 10'(b);
        req_c[i*10 +: 10] = 10'(c);
        req_d[i*10 +: 10] = 10'(d);
    endtask

    // Leaves the bench at the start of cycle 1 (reset released mid-cycle).
    task automatic do_reset();
        rst_n      = 1'b0;
        flush      = 1'b0;
        req_valid  = '0;
        req_valid3 = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 2'b11;
        set_ops(0, 1, 2, 3, 4);
        step();
        checks++;
        if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
        checks++;
        if (pipe_a !== 10'd0) begin failures++; $display("FAIL reset_pipe_a got=%0d exp=0", pipe_a); end
        checks++;
        if (resp_valid !== 2'b00 || resp_id !== 1'b0 || resp_f !== 10'd0) begin
            failures++; $display("FAIL reset_resp got=%b/%0d/%0d exp=00/0/0", resp_valid, resp_id, resp_f);
        end
        checks++;
        if (inflight !== 3'd0 || idle !== 1'b1) begin
            failures++; $display("FAIL reset_idle got inflight=%0d idle=%b exp 0/1", inflight, idle);
        end
        $display("test_reset done");
    endtask

    task automatic test_single();
        do_reset();
        set_ops(0, 10, 12, 6, 3);
        req_valid = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin failures++; $display("FAIL single_ready got=%b exp=01", req_ready); end
        checks++;
        if (pipe_a !== 10'd10 || pipe_d !== 10'd3) begin
            failures++; $display("FAIL single_pipe_ops got=%0d,%0d exp=10,3", pipe_a, pipe_d);
        end
        step();
        req_valid = 2'b00;
        #1;
        checks++;
        if (pipe_a !== 10'd0 || inflight !== 3'd1) begin
            failures++; $display("FAIL single_bubble got pipe_a=%0d inflight=%0d exp 0/1", pipe_a, inflight);
        end
        for (int cyc = 2; cyc <= 4; cyc++) begin
            checks++;
            if (resp_valid !== 2'b00) begin failures++; $display("FAIL single_early_resp cyc=%0d got=%b exp=00", cyc, resp_valid); end
            step();
        end
        checks++;
        if (resp_valid !== 2'b01 || resp_id !== 1'b0 || resp_f !== 10'd75) begin
            failures++; $display("FAIL single_resp got=%b/%0d/%0d exp=01/0/75", resp_valid, resp_id, resp_f);
        end
        checks++;
        if (idle !== 1'b0) begin failures++; $display("FAIL single_busy got idle=%b exp=0", idle); end
        step();
        checks++;
        if (idle !== 1'b1 || resp_valid !== 2'b00 || resp_f !== 10'd75) begin
            failures++; $display("FAIL single_idle got idle=%b valid=%b f=%0d exp 1/00/75", idle, resp_valid, resp_f);
        end
        $display("test_single done");
    endtask

    task automatic test_alternate();
        logic [1:0] exp_ready;
        logic [9:0] exp_f;
        do_reset();
        set_ops(0, 10, 10, 5, 3);
        set_ops(1, 20, 11, 1, 4);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            req_valid = (cyc <= 6) ? 2'b11 : 2'b00;
            #1;
            exp_ready = (cyc > 6) ? 2'b00 : (((cyc - 1) % 2 == 0) ? 2'b01 : 2'b10);
            checks++;
            if (req_ready !== exp_ready) begin
                failures++; $display("FAIL alt_grant cyc=%0d got=%b exp=%b", cyc, req_ready, exp_ready);
            end
            if (cyc == 4) begin
                checks++;
                if (inflight !== 3'd3) begin failures++; $display("FAIL alt_inflight got=%0d exp=3", inflight); end
            end
            if (cyc >= 5) begin
                exp_f = ((cyc - 5) % 2 == 0) ? 10'd66 : 10'd112;
                checks++;
                if (resp_valid !== (((cyc - 5) % 2 == 0) ? 2'b01 : 2'b10) ||
                    resp_id !== 1'((cyc - 5) % 2) || resp_f !== exp_f) begin
                    failures++; $display("FAIL alt_resp cyc=%0d got=%b/%0d/%0d exp_id=%0d exp_f=%0d",
                                         cyc, resp_valid, resp_id, resp_f, (cyc - 5) % 2, exp_f);
                end
            end
            step();
        end
        $display("test_alternate done");
    endtask

    task automatic test_flush();
        do_reset();
        set_ops(0, 15, 10, 8, 2);
        set_ops(1, 10, 20, 5, 3);
        req_valid = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin failures++; $display("FAIL flush_c1 got=%b exp=01", req_ready); end
        step();
        req_valid = 2'b10;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin failures++; $display("FAIL flush_c2 got=%b exp=10", req_ready); end
        step();
        req_valid = 2'b01;
        flush     = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin failures++; $display("FAIL flush_no_grant got=%b exp=00", req_ready); end
        step();
        flush = 1'b0;
        #1;
        checks++;
        if (req_ready !== 2'b01 || inflight !== 3'd0) begin
            failures++; $display("FAIL flush_c4 got ready=%b inflight=%0d exp 01/0", req_ready, inflight);
        end
        for (int cyc = 4; cyc <= 7; cyc++) begin
            checks++;
            if (resp_valid !== 2'b00) begin failures++; $display("FAIL flush_resp cyc=%0d got=%b exp=00", cyc, resp_valid); end
            step();
            req_valid = 2'b00;
        end
        checks++;
        if (resp_valid !== 2'b01 || resp_f !== 10'd62) begin
            failures++; $display("FAIL flush_after got=%b/%0d exp=01/62", resp_valid, resp_f);
        end
        $display("test_flush done");
    endtask

    task automatic test_async_reset();
        do_reset();
        set_ops(0, 10, 10, 5, 3);
        set_ops(1, 20, 11, 1, 4);
        for (int cyc = 1; cyc <= 3; cyc++) begin
            req_valid = 2'b11;
            step();
        end
        req_valid = 2'b00;
        step();
        checks++;
        if (resp_valid !== 2'b01 || resp_f !== 10'd66) begin
            failures++; $display("FAIL arst_pre got=%b/%0d exp=01/66", resp_valid, resp_f);
        end
        req_valid = 2'b11;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 2'b00 || req_ready !== 2'b00 || pipe_a !== 10'd0 || inflight !== 3'd0) begin
            failures++; $display("FAIL arst_immediate got valid=%b ready=%b pipe_a=%0d inflight=%0d exp 00/00/0/0",
                                 resp_valid, req_ready, pipe_a, inflight);
        end
        step();
        step();
        req_valid = 2'b00;
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if (resp_valid !== 2'b00) begin failures++; $display("FAIL arst_stale k=%0d got=%b exp=00", k, resp_valid); end
        end
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin failures++; $display("FAIL arst_ptr got=%b exp=01", req_ready); end
        step();
        req_valid = 2'b00;
        step();
        step();
        step();
        checks++;
        if (resp_valid !== 2'b01 || resp_f !== 10'd66) begin
            failures++; $display("FAIL arst_new got=%b/%0d exp=01/66", resp_valid, resp_f);
        end
        $display("test_async_reset done");
    endtask

    task automatic test_rr3();
        logic [2:0] exp_ready;
        bit granted;
        do_reset();
        req_valid3 = 3'b110;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            #1;
            exp_ready = (cyc % 2 == 1) ? 3'b010 : 3'b100;
            checks++;
            if (req_ready3 !== exp_ready) begin
                failures++; $display("FAIL rr3_grant cyc=%0d got=%b exp=%b", cyc, req_ready3, exp_ready);
            end
            step();
        end
        req_valid3 = 3'b111;
        granted    = 1'b0;
        for (int k = 0; k < 3 && !granted; k++) begin
            #1;
            if (req_ready3 === 3'b001) begin
                granted = 1'b1;
            end else begin
                step();
            end
        end
        checks++;
        if (!granted) begin failures++; $display("FAIL rr3_req0_grant got=%b exp=001 within 3 cycles", req_ready3); end
        req_valid3 = 3'b000;
        $display("test_rr3 done");
    endtask

    task automatic test_zero_and_bubbles();
        logic [1:0] exp_valid;
        do_reset();
        for (int cyc = 1; cyc <= 9; cyc++) begin
            if (cyc == 1) begin
                set_ops(0, 8, 15, 5, 0);
                req_valid = 2'b01;
            end else if (cyc == 4) begin
                set_ops(0, 10, 10, 30, 1);
                req_valid = 2'b01;
            end else begin
                req_valid = 2'b00;
            end
            #1;
            exp_valid = (cyc == 5 || cyc == 8) ? 2'b01 : 2'b00;
            checks++;
            if (resp_valid !== exp_valid) begin
                failures++; $display("FAIL zb_valid cyc=%0d got=%b exp=%b", cyc, resp_valid, exp_valid);
            end
            if (cyc == 5) begin
                checks++;
                if (resp_f !== 10'd0) begin failures++; $display("FAIL zb_zero got=%0d exp=0", resp_f); end
            end
            if (cyc == 8) begin
                checks++;
                if (resp_f !== 10'd49) begin failures++; $display("FAIL zb_49 got=%0d exp=49", resp_f); end
            end
            step();
        end
        $display("test_zero_and_bubbles done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_alternate();
        test_flush();
        test_async_reset();
        test_rr3();
        test_zero_and_bubbles();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
